// File: rtl/fetch_pkg.sv
// Shared enums and default constants for the fetch/branch stage.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package fetch_pkg;

    localparam int          DEF_XLEN     = 32;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } br_funct3_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// In-order instruction buffer with synchronous clear; DEPTH must be a power of two.
// Latency: a push is visible at the head on the following cycle.
// Backpressure: push is ignored when full, pop is ignored when empty.
module fetch_fifo #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/fetch_branch_unit.sv
// Fetch stage with B-type branch resolution; BRANCH_PERF_EN adds branch counters.
// Latency: memory latency + 1 cycle from request to id_valid_o; redirect is combinational.
// Backpressure: requests throttled so outstanding + buffered never exceeds FIFO_DEPTH.
module fetch_branch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN       = DEF_XLEN,
    parameter logic [XLEN-1:0] RESET_PC   = XLEN'(DEF_RESET_PC),
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_rdy_i,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    output logic            id_valid_o,
    output logic [31:0]     id_instr_o,
    output logic [XLEN-1:0] id_pc_o,
    input  logic            id_ready_i,
    input  logic            br_valid_i,
    input  logic [2:0]      br_funct3_i,
    input  logic [XLEN-1:0] br_rs1_i,
    input  logic [XLEN-1:0] br_rs2_i,
    input  logic [XLEN-1:0] br_pc_i,
    input  logic [12:0]     br_imm_i,
`ifdef BRANCH_PERF_EN
    output logic [31:0]     br_total_cnt_o,
    output logic [31:0]     br_taken_cnt_o,
`endif
    output logic            redirect_o,
    output logic [XLEN-1:0] br_target_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
    } fetch_ent_t;

    fetch_state_e    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] resp_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   outstanding_nxt;
    logic [CW-1:0]   fifo_count;
    logic            fifo_full;
    logic            fifo_empty;
    logic            accept;
    logic            push;
    logic            cond;
    logic            taken;
    logic [XLEN-1:0] target;
    fetch_ent_t      push_ent;
    fetch_ent_t      head_ent;

    always_comb begin
        cond = 1'b0;
        case (br_funct3_i)
            BEQ:     cond = (br_rs1_i == br_rs2_i);
            BNE:     cond = (br_rs1_i != br_rs2_i);
            BLT:     cond = ($signed(br_rs1_i) <  $signed(br_rs2_i));
            BGE:     cond = ($signed(br_rs1_i) >= $signed(br_rs2_i));
            BLTU:    cond = (br_rs1_i <  br_rs2_i);
            BGEU:    cond = (br_rs1_i >= br_rs2_i);
            default: cond = 1'b0;
        endcase
    end

    assign taken       = br_valid_i && cond;
    assign target      = (br_pc_i + {{(XLEN-13){br_imm_i[12]}}, br_imm_i}) & {{(XLEN-1){1'b1}}, 1'b0};
    assign redirect_o  = taken;
    assign br_target_o = br_valid_i ? target : '0;

    assign imem_addr_o     = pc;
    assign imem_req_o      = (state == RUN) &&
                             (({1'b0, outstanding} + {1'b0, fifo_count}) < (CW+1)'(FIFO_DEPTH));
    assign accept          = imem_req_o && imem_rdy_i;
    assign outstanding_nxt = outstanding + CW'(accept) - CW'(imem_rvalid_i);

    // Responses are in order and every wrong-path one is discarded, so resp_pc
    // only needs to advance on kept pushes and follow the target on a redirect.
    assign push     = imem_rvalid_i && (state == RUN) && !taken && !fifo_full;
    assign push_ent = '{instr: imem_rdata_i, pc: resp_pc};

    fetch_fifo #(
        .WIDTH ($bits(fetch_ent_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (taken),
        .push     (push),
        .push_dat (push_ent),
        .pop      (id_ready_i),
        .pop_dat  (head_ent),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign id_valid_o = !fifo_empty;
    assign id_instr_o = fifo_empty ? '0 : head_ent.instr;
    assign id_pc_o    = fifo_empty ? '0 : head_ent.pc;

    // In FLUSH the outstanding count doubles as the drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            if (taken) begin
                pc      <= target;
                resp_pc <= target;
            end else begin
                if (accept) pc      <= pc + XLEN'(4);
                if (push)   resp_pc <= resp_pc + XLEN'(4);
            end
            case (state)
                IDLE:    state <= RUN;
                default: state <= ((taken || state == FLUSH) && outstanding_nxt != '0) ? FLUSH : RUN;
            endcase
        end
    end

`ifdef BRANCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_total_cnt_o <= '0;
            br_taken_cnt_o <= '0;
        end else begin
            if (br_valid_i && br_total_cnt_o != '1) br_total_cnt_o <= br_total_cnt_o + 32'd1;
            if (taken && br_taken_cnt_o != '1)      br_taken_cnt_o <= br_taken_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_branch_unit.sv
// Directed bench for fetch_branch_unit with a queue-based reference model and in-order memory.
module tb_fetch_branch_unit;

    localparam int          XLEN = 32;
    localparam int          D    = 2;
    localparam logic [31:0] RPC  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_rdy_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        id_valid_o;
    logic [31:0] id_instr_o;
    logic [31:0] id_pc_o;
    logic        id_ready_i = 1'b0;
    logic        br_valid_i = 1'b0;
    logic [2:0]  br_funct3_i = '0;
    logic [31:0] br_rs1_i = '0;
    logic [31:0] br_rs2_i = '0;
    logic [31:0] br_pc_i = '0;
    logic [12:0] br_imm_i = '0;
    logic        redirect_o;
    logic [31:0] br_target_o;
`ifdef BRANCH_PERF_EN
    logic [31:0] br_total_cnt;
    logic [31:0] br_taken_cnt;
`endif

    fetch_branch_unit #(.XLEN(XLEN), .RESET_PC(RPC), .FIFO_DEPTH(D)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_rdy_i    (imem_rdy_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .id_valid_o    (id_valid_o),
        .id_instr_o    (id_instr_o),
        .id_pc_o       (id_pc_o),
        .id_ready_i    (id_ready_i),
        .br_valid_i    (br_valid_i),
        .br_funct3_i   (br_funct3_i),
        .br_rs1_i      (br_rs1_i),
        .br_rs2_i      (br_rs2_i),
        .br_pc_i       (br_pc_i),
        .br_imm_i      (br_imm_i),
`ifdef BRANCH_PERF_EN
        .br_total_cnt_o(br_total_cnt),
        .br_taken_cnt_o(br_taken_cnt),
`endif
        .redirect_o    (redirect_o),
        .br_target_o   (br_target_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: outstanding requests (with wrong-path tag) and the decode buffer.
    typedef struct { logic [31:0] pc; bit stale; } ent_t;
    ent_t        out_q[$];
    logic [31:0] fq_pc[$];
    logic [31:0] fq_ins[$];
    logic [31:0] m_pc;
    bit          m_idle;

    // Memory environment: accepted addresses with their due cycle.
    logic [31:0] mem_addr_q[$];
    int          mem_due_q[$];

    bit          idr_k = 1'b1;
    bit          rdy_k = 1'b1;
    bit          rdy_toggle = 1'b0;
    int          lat_k = 1;
    bit          lit_en = 1'b0;
    logic        lit_taken;
    logic [31:0] lit_tgt;
    string       lit_name;
    logic [31:0] deliv[$];

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return ~a ^ 32'h1357_9BDF;
    endfunction

    function automatic bit m_taken(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] sa;
        logic [31:0] sb;
        sa = a ^ 32'h8000_0000;
        sb = b ^ 32'h8000_0000;
        case (f)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return sa < sb;
            3'b101:  return sa >= sb;
            3'b110:  return a < b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] tgt_of(input logic [31:0] bpc, input logic [12:0] imm);
        int off;
        off = int'(imm);
        if (imm[12]) off = off - 8192;
        return (bpc + 32'(off)) & 32'hFFFF_FFFE;
    endfunction

    function automatic bit any_stale();
        foreach (out_q[i]) if (out_q[i].stale) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] dget(input int i);
        if (i < deliv.size()) return deliv[i];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        out_q.delete();
        fq_pc.delete();
        fq_ins.delete();
        mem_addr_q.delete();
        mem_due_q.delete();
        m_pc   = RPC;
        m_idle = 1'b1;
    endtask

    task automatic cycle();
        bit          m_req;
        bit          tk;
        bit          rv;
        bit          acc;
        bit          d_acc;
        bit          rst_s;
        logic [31:0] d_addr;
        logic [31:0] tgt;
        ent_t        e;
        imem_rdy_i    = rdy_toggle ? (cyc % 3 != 0) : rdy_k;
        id_ready_i    = idr_k;
        rv            = rst_n && mem_addr_q.size() > 0 && mem_due_q[0] <= cyc;
        imem_rvalid_i = rv;
        imem_rdata_i  = rv ? instr_of(mem_addr_q[0]) : 32'h0;
        @(negedge clk);
        m_req = rst_n && !m_idle && !any_stale() && (out_q.size() + fq_pc.size() < D);
        tk    = br_valid_i && m_taken(br_funct3_i, br_rs1_i, br_rs2_i);
        tgt   = br_valid_i ? tgt_of(br_pc_i, br_imm_i) : 32'h0;
        chk("imem_req", imem_req_o, m_req);
        chk("imem_addr", imem_addr_o, m_pc);
        chk("id_valid", id_valid_o, fq_pc.size() > 0);
        chk("id_pc", id_pc_o, fq_pc.size() > 0 ? fq_pc[0] : 32'h0);
        chk("id_instr", id_instr_o, fq_ins.size() > 0 ? fq_ins[0] : 32'h0);
        chk("redirect", redirect_o, tk);
        chk("br_target", br_target_o, tgt);
        if (lit_en) begin
            chk({lit_name, "_redirect"}, redirect_o, lit_taken);
            chk({lit_name, "_target"}, br_target_o, lit_tgt);
            lit_en = 1'b0;
        end
        if (id_valid_o && id_ready_i) deliv.push_back(id_pc_o);
        d_acc  = imem_req_o && imem_rdy_i;
        d_addr = imem_addr_o;
        rst_s  = rst_n;
        @(posedge clk);
        if (!rst_s) begin
            model_reset();
        end else begin
            if (rv) begin
                void'(mem_addr_q.pop_front());
                void'(mem_due_q.pop_front());
            end
            if (d_acc) begin
                mem_addr_q.push_back(d_addr);
                mem_due_q.push_back(cyc + lat_k);
            end
            acc = m_req && imem_rdy_i;
            if (idr_k && fq_pc.size() > 0) begin
                void'(fq_pc.pop_front());
                void'(fq_ins.pop_front());
            end
            if (rv && out_q.size() > 0) begin
                e = out_q.pop_front();
                if (!e.stale && !tk && !m_idle) begin
                    fq_pc.push_back(e.pc);
                    fq_ins.push_back(instr_of(e.pc));
                end
            end
            if (acc) out_q.push_back('{m_pc, 1'b0});
            if (tk) begin
                fq_pc.delete();
                fq_ins.delete();
                foreach (out_q[i]) out_q[i].stale = 1'b1;
                m_pc = tgt;
            end else if (acc) begin
                m_pc = m_pc + 32'd4;
            end
            m_idle = 1'b0;
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset(input string nm, input int n);
        rst_n = 1'b0;
        model_reset();
        repeat (n) cycle();
        chk({nm, "_req"}, imem_req_o, 32'h0);
        chk({nm, "_addr"}, imem_addr_o, RPC);
        chk({nm, "_id_valid"}, id_valid_o, 32'h0);
        chk({nm, "_id_instr"}, id_instr_o, 32'h0);
        chk({nm, "_id_pc"}, id_pc_o, 32'h0);
        chk({nm, "_redirect"}, redirect_o, 32'h0);
        chk({nm, "_target"}, br_target_o, 32'h0);
        rst_n = 1'b1;
    endtask

    task automatic branch(input string nm, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] p, input logic [12:0] imm,
                          input logic et, input logic [31:0] etgt);
        br_valid_i  = 1'b1;
        br_funct3_i = f;
        br_rs1_i    = a;
        br_rs2_i    = b;
        br_pc_i     = p;
        br_imm_i    = imm;
        lit_en      = 1'b1;
        lit_taken   = et;
        lit_tgt     = etgt;
        lit_name    = nm;
        cycle();
        br_valid_i  = 1'b0;
    endtask

    initial begin
        int first_req;
        int first_vld;
        int n0;
        #1;
        // Reset release with an instant memory.
        do_reset("rst", 3);
        first_req = -1;
        first_vld = -1;
        n0 = deliv.size();
        for (int k = 0; k < 12; k++) begin
            if (first_req < 0 && imem_req_o) first_req = k;
            if (first_vld < 0 && id_valid_o) first_vld = k;
            cycle();
        end
        chk("first_req_cycle", first_req, 1);
        chk("first_valid_cycle", first_vld, 3);
        chk("seq0", dget(n0), 32'h0);
        chk("seq1", dget(n0 + 1), 32'h4);
        chk("seq2", dget(n0 + 2), 32'h8);

        // bne back to 0 while 12 is in flight.
        do_reset("rst2", 2);
        for (int i = 0; i < 40 && m_pc != 32'h10; i++) cycle();
        branch("bne", 3'b001, 32'd5, 32'd3, 32'h8, 13'h1FF8, 1'b1, 32'h0);
        chk("bne_next_addr", imem_addr_o, 32'h0);
        n0 = deliv.size();
        repeat (12) cycle();
        chk("bne_first_deliv", dget(n0), 32'h0);
        chk("bne_second_deliv", dget(n0 + 1), 32'h4);

        // beq taken and not taken.
        branch("beq_t", 3'b000, 32'd7, 32'd7, 32'h20, 13'd16, 1'b1, 32'h30);
        chk("beq_next_addr", imem_addr_o, 32'h30);
        n0 = deliv.size();
        repeat (8) cycle();
        chk("beq_first_deliv", dget(n0), 32'h30);
        branch("beq_nt", 3'b000, 32'd7, 32'd8, 32'h20, 13'd16, 1'b0, 32'h30);
        repeat (4) cycle();

        // Signed vs unsigned compares, unused encodings, odd immediate, wrap.
        branch("blt",  3'b100, 32'hFFFF_FFFF, 32'd1, 32'h40, 13'd8, 1'b1, 32'h48);
        repeat (2) cycle();
        branch("bltu", 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h40, 13'd8, 1'b0, 32'h48);
        branch("bge",  3'b101, 32'hFFFF_FFFF, 32'd1, 32'h40, 13'd8, 1'b0, 32'h48);
        branch("bgeu", 3'b111, 32'hFFFF_FFFF, 32'd1, 32'h40, 13'd8, 1'b1, 32'h48);
        repeat (2) cycle();
        branch("f010", 3'b010, 32'd9, 32'd9, 32'h40, 13'd8, 1'b0, 32'h48);
        branch("f011", 3'b011, 32'd1, 32'd9, 32'h40, 13'd8, 1'b0, 32'h48);
        branch("odd_imm", 3'b111, 32'd3, 32'd3, 32'h100, 13'h1FFF, 1'b1, 32'hFE);
        repeat (3) cycle();
        branch("wrap", 3'b000, 32'd0, 32'd0, 32'hFFFF_FFFC, 13'd8, 1'b1, 32'h4);
        repeat (6) cycle();

        // Decode stall: throttling and in-order release.
        idr_k = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("stall_pending", mem_addr_q.size() <= D, 32'h1);
        end
        chk("stall_req_off", imem_req_o, 32'h0);
        chk("stall_full_valid", id_valid_o, 32'h1);
        n0 = deliv.size();
        idr_k = 1'b1;
        repeat (10) cycle();
        chk("release_order1", dget(n0 + 1), dget(n0) + 32'd4);
        chk("release_order2", dget(n0 + 2), dget(n0 + 1) + 32'd4);

        // Long latency: branch into FLUSH, then re-target during FLUSH.
        lat_k = 3;
        repeat (6) cycle();
        branch("flush_a", 3'b001, 32'd1, 32'd2, 32'h200, 13'h10, 1'b1, 32'h210);
        branch("flush_b", 3'b000, 32'd4, 32'd4, 32'h300, 13'h20, 1'b1, 32'h320);
        n0 = deliv.size();
        repeat (15) cycle();
        chk("flush_first_deliv", dget(n0), 32'h320);

        // Irregular memory acceptance.
        lat_k = 2;
        rdy_toggle = 1'b1;
        repeat (20) cycle();
        rdy_toggle = 1'b0;

        // Reset pulsed during FLUSH with two requests outstanding.
        do_reset("rst3", 2);
        lat_k = 3;
        repeat (3) cycle();
        chk("flush_setup_pending", mem_addr_q.size(), 32'd2);
        branch("flush_c", 3'b000, 32'd1, 32'd1, 32'h80, 13'h40, 1'b1, 32'hC0);
        chk("flush_c_req_off", imem_req_o, 32'h0);
        chk("flush_c_addr", imem_addr_o, 32'hC0);
        do_reset("rst_mid", 2);
        n0 = deliv.size();
        repeat (14) cycle();
        chk("restart_first", dget(n0), RPC);
        chk("restart_second", dget(n0 + 1), RPC + 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
